// File: rtl/req_ack_delay_mc.sv
// req_ack_delay_mc: N independent request/acknowledge delay channels.
// A rising edge on req[i] starts a count of the programmed delay (0 treated
// as 1). When that many cycles have elapsed, ack[i] is raised. An edge that
// arrives while the channel is already counting is either dropped (RETRIG=0)
// or restarts the count (RETRIG=1).
// Optional feature macro: REQ_ACK_LEVEL_EN. When it is defined, ack[i] is
// held high until req[i] is sampled low. Otherwise ack[i] is a one-cycle pulse.
module req_ack_delay_mc #(
  parameter int N      = 4,
  parameter int DW     = 4,
  parameter int RETRIG = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [DW-1:0] delay,
  output logic [N-1:0]  ack,
  output logic [N-1:0]  busy,
  output logic [N-1:0]  drop
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t        state      [N];
  state_t        state_next [N];
  logic [DW-1:0] dl         [N];
  logic [DW-1:0] dl_next    [N];
  logic [DW-1:0] cnt        [N];
  logic [DW-1:0] cnt_next   [N];

  logic [N-1:0]  req_d;
  logic [N-1:0]  rise;
  logic [N-1:0]  done;
  logic [N-1:0]  ack_next;
  logic [N-1:0]  busy_next;
  logic [N-1:0]  drop_next;
  logic [DW-1:0] delay_eff;

  // A programmed delay of zero behaves exactly like a delay of one.
  assign delay_eff = (delay == '0) ? DW'(1) : delay;
  assign rise      = req & ~req_d;

  // Next-state and output logic for every channel.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      // NOTE: every signal gets a default value before any branch. A path
      // that leaves one unassigned would infer a latch.
      state_next[i] = state[i];
      dl_next[i]    = dl[i];
      cnt_next[i]   = cnt[i];
      drop_next[i]  = 1'b0;
`ifdef REQ_ACK_LEVEL_EN
      // Hold ack only while req has stayed high since the completing edge.
      ack_next[i]   = ack[i] & req[i] & req_d[i];
`else
      ack_next[i]   = 1'b0;
`endif
      // The completing edge is the one at which the count reaches the latched delay.
      done[i] = (state[i] == COUNT) &&
                (({1'b0, cnt[i]} + (DW+1)'(1)) == {1'b0, dl[i]});

      case (state[i])
        IDLE: begin
          if (rise[i]) begin
            state_next[i] = COUNT;
            dl_next[i]    = delay_eff;
            cnt_next[i]   = '0;
          end
        end
        COUNT: begin
          if (done[i]) begin
            ack_next[i] = 1'b1;
            // An edge on the completing cycle starts a fresh transaction.
            if (rise[i]) begin
              dl_next[i]  = delay_eff;
              cnt_next[i] = '0;
            end else begin
              state_next[i] = IDLE;
            end
          end else if (rise[i] && (RETRIG != 0)) begin
            dl_next[i]  = delay_eff;
            cnt_next[i] = '0;
          end else begin
            drop_next[i] = rise[i];
            cnt_next[i]  = cnt[i] + DW'(1);
          end
        end
        default: state_next[i] = IDLE;
      endcase

      busy_next[i] = (state_next[i] == COUNT);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state, so every
    // register samples its pre-edge value regardless of statement order.
    if (rst) begin
      // NOTE: the per-channel delay and counter arrays are reset as well.
      // They are tiny, and resetting them keeps the simulation free of X values.
      for (int i = 0; i < N; i++) begin
        state[i] <= IDLE;
        dl[i]    <= '0;
        cnt[i]   <= '0;
      end
      req_d <= '0;
      ack   <= '0;
      busy  <= '0;
      drop  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state[i] <= state_next[i];
        dl[i]    <= dl_next[i];
        cnt[i]   <= cnt_next[i];
      end
      req_d <= req;
      ack   <= ack_next;
      busy  <= busy_next;
      drop  <= drop_next;
    end
  end

endmodule

// File: tb/tb_req_ack_delay_mc.sv
// Self-checking bench for req_ack_delay_mc. Two instances are driven by the
// same stimulus: one with RETRIG=0 and one with RETRIG=1. A behavioural model
// keeps an absolute due-cycle per channel and predicts ack, busy and drop.
module tb_req_ack_delay_mc;

  localparam int N  = 4;
  localparam int DW = 4;
`ifdef REQ_ACK_LEVEL_EN
  localparam bit LEVEL = 1'b1;
`else
  localparam bit LEVEL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_s;
  logic [N-1:0]  req_s;
  logic [DW-1:0] delay_s;
  logic [N-1:0]  ack0, busy0, drop0, ack1, busy1, drop1;

  int checks   = 0;
  int failures = 0;

  // Model state: index 0 = drop policy, index 1 = retrigger policy.
  int           t = 0;
  logic         bsy_m  [2][N];
  int           due_m  [2][N];
  logic [N-1:0] ack_m  [2];
  logic [N-1:0] drop_m [2];
  logic [N-1:0] reqd_m;

  always #5 clk = ~clk;

  req_ack_delay_mc #(.N(N), .DW(DW), .RETRIG(0)) dut0 (
    .clk(clk), .rst(rst_s), .req(req_s), .delay(delay_s),
    .ack(ack0), .busy(busy0), .drop(drop0));

  req_ack_delay_mc #(.N(N), .DW(DW), .RETRIG(1)) dut1 (
    .clk(clk), .rst(rst_s), .req(req_s), .delay(delay_s),
    .ack(ack1), .busy(busy1), .drop(drop1));

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0d: got %b expected %b", name, t, act, exp);
    end
  endtask

  // Advances the model by one clock edge, using the inputs sampled at that edge.
  task automatic model_edge();
    logic [N-1:0] rise;
    int           d;
    logic         comp, a_new, dr;
    rise = req_s & ~reqd_m;
    d    = (delay_s == 0) ? 1 : int'(delay_s);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        if (rst_s) begin
          bsy_m[k][i]  = 1'b0;
          ack_m[k][i]  = 1'b0;
          drop_m[k][i] = 1'b0;
        end else begin
          comp  = bsy_m[k][i] && (t == due_m[k][i]);
          a_new = comp | (LEVEL & ack_m[k][i] & req_s[i] & reqd_m[i]);
          dr    = 1'b0;
          if (comp) begin
            bsy_m[k][i] = rise[i];
            if (rise[i]) due_m[k][i] = t + d;
          end else if (bsy_m[k][i]) begin
            if (rise[i]) begin
              if (k == 1) due_m[k][i] = t + d;
              else        dr = 1'b1;
            end
          end else if (rise[i]) begin
            bsy_m[k][i] = 1'b1;
            due_m[k][i] = t + d;
          end
          ack_m[k][i]  = a_new;
          drop_m[k][i] = dr;
        end
      end
    end
    reqd_m = rst_s ? '0 : req_s;
  endtask

  // Applies one cycle of inputs, then checks both DUTs against the model.
  task automatic step(input logic r, input logic [N-1:0] q, input logic [DW-1:0] d);
    logic [N-1:0] bv0, bv1;
    rst_s   = r;
    req_s   = q;
    delay_s = d;
    @(posedge clk);
    #1;
    t++;
    model_edge();
    for (int i = 0; i < N; i++) begin
      bv0[i] = bsy_m[0][i];
      bv1[i] = bsy_m[1][i];
    end
    check("ack_r0",  ack0,  ack_m[0]);
    check("busy_r0", busy0, bv0);
    check("drop_r0", drop0, drop_m[0]);
    check("ack_r1",  ack1,  ack_m[1]);
    check("busy_r1", busy1, bv1);
    check("drop_r1", drop1, drop_m[1]);
  endtask

  initial begin
    logic [N-1:0]  rq;
    logic [DW-1:0] dv;
    reqd_m = '0;
    for (int k = 0; k < 2; k++) begin
      ack_m[k]  = '0;
      drop_m[k] = '0;
      for (int i = 0; i < N; i++) begin
        bsy_m[k][i] = 1'b0;
        due_m[k][i] = 0;
      end
    end

    // Reset state.
    repeat (3) step(1'b1, '0, 4'd5);
    check("lit_rst_ack",  ack0,  4'b0000);
    check("lit_rst_busy", busy0, 4'b0000);
    check("lit_rst_drop", drop0, 4'b0000);

    // Basic delay of 5 cycles on channel 0.
    repeat (2) step(1'b0, 4'b0000, 4'd5);
    step(1'b0, 4'b0001, 4'd5);                 // E0
    check("lit_basic_busy_e0", busy0, 4'b0001);
    repeat (4) step(1'b0, 4'b0001, 4'd5);      // E0+1..E0+4
    check("lit_basic_busy_e4", busy0, 4'b0001);
    check("lit_basic_ack_e4",  ack0,  4'b0000);
    step(1'b0, 4'b0000, 4'd5);                 // E0+5
    check("lit_basic_ack_e5",  ack0,  4'b0001);
    check("lit_basic_busy_e5", busy0, 4'b0000);
    step(1'b0, 4'b0000, 4'd5);
    check("lit_basic_ack_e6",  ack0,  4'b0000);

    // Edge while busy on channel 1 with delay 6.
    step(1'b0, 4'b0010, 4'd6);                 // E0
    step(1'b0, 4'b0000, 4'd6);
    step(1'b0, 4'b0010, 4'd6);                 // E0+2
    check("lit_drop_r0", drop0, 4'b0010);
    check("lit_drop_r1", drop1, 4'b0000);
    repeat (3) step(1'b0, 4'b0000, 4'd6);      // E0+3..E0+5
    step(1'b0, 4'b0000, 4'd6);                 // E0+6
    check("lit_busyedge_ack_r0", ack0, 4'b0010);
    check("lit_busyedge_ack_r1", ack1, 4'b0000);
    step(1'b0, 4'b0000, 4'd6);
    step(1'b0, 4'b0000, 4'd6);                 // E0+8
    check("lit_retrig_ack_r1", ack1, 4'b0010);
    repeat (2) step(1'b0, 4'b0000, 4'd6);

    // Edge on the completing cycle on channel 3 with delay 4.
    step(1'b0, 4'b1000, 4'd4);                 // E0
    repeat (3) step(1'b0, 4'b0000, 4'd4);
    step(1'b0, 4'b1000, 4'd4);                 // E0+4
    check("lit_comp_ack_e4",  ack0,  4'b1000);
    check("lit_comp_busy_e4", busy0, 4'b1000);
    check("lit_comp_drop_e4", drop0, 4'b0000);
    repeat (3) step(1'b0, 4'b0000, 4'd4);
    step(1'b0, 4'b0000, 4'd4);                 // E0+8
    check("lit_comp_ack_e8",  ack0,  4'b1000);
    check("lit_comp_busy_e8", busy0, 4'b0000);

    // Delay 15, changed to 3 while counting.
    step(1'b0, 4'b0100, 4'd15);                // E0
    repeat (14) step(1'b0, 4'b0000, 4'd3);
    check("lit_d15_ack_e14", ack0, 4'b0000);
    step(1'b0, 4'b0000, 4'd3);                 // E0+15
    check("lit_d15_ack_e15", ack0, 4'b0100);

    // Delay 0 behaves like 1.
    step(1'b0, 4'b0001, 4'd0);
    step(1'b0, 4'b0000, 4'd0);
    check("lit_d0_ack", ack0, 4'b0001);
    step(1'b0, 4'b0000, 4'd0);

    // Reset mid-count, then req held high through reset release.
    step(1'b0, 4'b0001, 4'd5);                 // E0
    step(1'b0, 4'b0001, 4'd5);
    step(1'b1, 4'b0001, 4'd5);                 // reset edge
    check("lit_rst_mid_busy", busy0, 4'b0000);
    step(1'b1, 4'b0001, 4'd5);
    step(1'b0, 4'b0001, 4'd5);                 // first post-reset edge
    check("lit_rst_rel_busy", busy0, 4'b0001);
    repeat (4) step(1'b0, 4'b0001, 4'd5);
    step(1'b0, 4'b0000, 4'd5);
    check("lit_rst_rel_ack", ack0, 4'b0001);
    step(1'b0, 4'b0000, 4'd5);

    // Channel 2 held high for 20 cycles with delay 5.
    step(1'b0, 4'b0100, 4'd5);                 // E0
    repeat (4) step(1'b0, 4'b0100, 4'd5);
    step(1'b0, 4'b0100, 4'd5);                 // E0+5
    check("lit_hold_ack_e5", ack0, 4'b0100);
    step(1'b0, 4'b0100, 4'd5);
    check("lit_hold_ack_e6", ack0, LEVEL ? 4'b0100 : 4'b0000);
    repeat (13) step(1'b0, 4'b0100, 4'd5);
    step(1'b0, 4'b0000, 4'd5);
    check("lit_hold_ack_fall", ack0, 4'b0000);
    repeat (2) step(1'b0, 4'b0000, 4'd5);

    // Randomised traffic checked against the model.
    rq = '0;
    dv = 4'd5;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 4) == 0) rq[i] = ~rq[i];
      if ($urandom_range(0, 7) == 0) dv = DW'($urandom_range(0, 15));
      step(($urandom_range(0, 299) == 0), rq, dv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_ack_delay_mc.md
# req_ack_delay_mc

Multi-channel request/acknowledge delay block. Each of `N` independent channels detects a rising edge on its `req` bit and returns an `ack` a run-time-programmable number of clock cycles later. Each channel has a busy flag and a configurable policy for requests that arrive while it is already counting. It sits between request sources and the handshake consumers in the control plane.

## Interface
- `N`, 4, number of independent channels (1..32)
- `DW`, 4, width of the delay value; delays range 1..2^DW-1
- `RETRIG`, 0, busy-edge policy: 0 = drop the new edge; 1 = restart the count

- `clk`  input  1  rising-edge clock; the only clock in the block
- `rst`  input  1  reset, synchronous and active-high
- `req`  input  N  per-channel request level; a rising edge starts a transaction
- `delay`  input  DW  delay in cycles, shared by all channels, latched per channel when an edge is accepted
- `ack`  output  N  per-channel acknowledge (see Configuration)
- `busy`  output  N  channel is counting
- `drop`  output  N  one-cycle pulse: an edge was rejected (only when `RETRIG`=0)

## Operation
- Each channel has a registered copy `req_d[i]` of `req[i]`.
- Edge condition: `req[i] & ~req_d[i]`, sampled at the clock edge.
- Per-channel state is IDLE or COUNT. The channel holds a latched delay `dl[i]` and a counter `cnt[i]` (DW bits).
- IDLE, on edge:
  - latch `dl` = `delay`; `delay`=0 is treated as 1;
  - go to COUNT; `busy` rises.
- COUNT: the counter advances once per cycle. When the latched delay has elapsed, the channel issues `ack` and returns to IDLE; `busy` falls at the same clock edge that `ack` rises.
- Edge while in COUNT, not on the completing cycle:
  - `RETRIG`=0: edge ignored; `drop[i]` pulses for one cycle; the count continues unchanged.
  - `RETRIG`=1: re-latch `delay` and restart the count from the new edge. The old transaction produces no `ack` and `drop` stays 0.
- Edge on the completing cycle: the `ack` for the old transaction is still issued. The new edge is accepted as a fresh transaction, so `busy` stays 1. No `drop` is raised under either policy.
- A change on `delay` while a channel is in COUNT does not affect that channel.
- Channels are fully independent. Any combination of simultaneous edges, acks and drops across channels is legal.

## Timing
- Reset values:
  - `ack`, `busy`, `drop` = 0;
  - every `req_d` = 0;
  - every channel in IDLE.
- `req` is high at the first clock edge after `rst` deasserts: this counts as a rising edge.
- `rst` asserted mid-count aborts the transaction. No `ack` follows, and all outputs are 0 from the next edge.
- Latency. Let edge E0 be the clock edge at which the rising edge is detected (`req`=1, `req_d`=0). Then:
  - `busy` is 1 from after E0 until edge E0+D, where D = latched delay;
  - `ack` rises after edge E0+D;
  - with D=5, `ack` rises 5 cycles after E0, the same cadence as the existing 5-cycle edge-to-ack block.
- `drop` is registered and is high for the cycle after the rejecting edge.
- All outputs are registered. There is no combinational path from an input to an output.

## Configuration
- Macro: `REQ_ACK_LEVEL_EN`.
- Undefined (default): `ack[i]` is a single-cycle pulse after edge E0+D.
- Defined: `ack[i]` rises after E0+D and stays high until the first clock edge at which `req[i]` is sampled 0; it clears after that edge.
  - If `req[i]` is already 0 at E0+D, `ack` is a one-cycle pulse.
  - `busy` timing is unchanged.
  - A new edge cannot occur while `ack` is held, because `req` must first fall.

## Test plan
- Basic delay: N=4, `delay`=5, `req[0]` rises at edge 10 -> `ack[0]`=1 for exactly the cycle after edge 15; `busy[0]`=1 over edges 10..14; other channels stay 0.
- Delay range: run `delay`=1, `delay`=15 and `delay`=0 -> `ack` after E0+1, E0+15 and E0+1 respectively. Change `delay` to 3 mid-count of a 15-cycle transaction -> `ack` still after E0+15.
- Busy edge, `RETRIG`=0: edges on `req[1]` at E0 and E0+2 with `delay`=6 -> one `ack` after E0+6, `drop[1]`=1 after E0+2. With `RETRIG`=1, the same stimulus -> one `ack` after E0+8 and no `drop`.
- Completing-cycle edge: `delay`=4, edges at E0 and E0+4 -> `ack` after E0+4 and again after E0+8; `busy` held 1 across E0+4; `drop`=0.
- Reset: `rst` at E0+2 of a 5-cycle count -> no `ack`, `busy` 0 from E0+3. `req` held high through reset release -> treated as an edge; `ack` 5 cycles after the first post-reset edge.
- `REQ_ACK_LEVEL_EN` defined: `req[2]` held high for 20 cycles with `delay`=5 -> `ack[2]` high from after E0+5 until the edge where `req[2]` is sampled 0. Without the macro, the same stimulus -> a one-cycle pulse.
